// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with a multi-cycle shift-add multiplier for mult, multu, madd and msub.
// mthi/mtlo write HI/LO in a single cycle; multiply-class ops hold the unit busy for ITER+1 edges.
module hilo_muldiv_unit #(
    parameter int DATA_W     = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              OpValid,
    input  logic [2:0]        Op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              OpReady,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO
);
    localparam int ITER  = DATA_W / RADIX_BITS;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int PW    = 2 * DATA_W;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_MADD  = 3'd3;
    localparam logic [2:0] OP_MSUB  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIN} state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [PW-1:0]     mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [PW-1:0]     prod_q;
    logic              sign_q;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] hi_q, lo_q;
    logic              done_q;

    logic              is_signed;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic [PW-1:0]     prod_d, fin_p, res_d;

    // Signed ops multiply magnitudes; the sign is reapplied once at FIN.
    assign is_signed = (Op == OP_MULT) || (Op == OP_MADD) || (Op == OP_MSUB);
    assign a_mag     = (is_signed && A[DATA_W-1]) ? -A : A;
    assign b_mag     = (is_signed && B[DATA_W-1]) ? -B : B;

    always_comb begin
        prod_d = prod_q;
        for (int i = 0; i < RADIX_BITS; i++)
            if (mplier_q[i]) prod_d = prod_d + (mcand_q << i);
    end

    assign fin_p = sign_q ? -prod_q : prod_q;

    always_comb begin
        res_d = fin_p;
        case (op_q)
            OP_MADD: res_d = {hi_q, lo_q} + fin_p;
            OP_MSUB: res_d = {hi_q, lo_q} - fin_p;
            default: res_d = fin_p;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            sign_q   <= 1'b0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (OpValid) begin
                    case (Op)
                        OP_MTHI: begin hi_q <= A; done_q <= 1'b1; end
                        OP_MTLO: begin lo_q <= A; done_q <= 1'b1; end
                        OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                            mcand_q  <= {{DATA_W{1'b0}}, a_mag};
                            mplier_q <= b_mag;
                            sign_q   <= is_signed & (A[DATA_W-1] ^ B[DATA_W-1]);
                            prod_q   <= '0;
                            op_q     <= Op;
                            cnt_q    <= '0;
                            state_q  <= S_MUL;
                        end
                        default: ;
                    endcase
                end
                S_MUL: begin
                    prod_q   <= prod_d;
                    mcand_q  <= mcand_q << RADIX_BITS;
                    mplier_q <= mplier_q >> RADIX_BITS;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER - 1)) state_q <= S_FIN;
                end
                S_FIN: begin
                    {hi_q, lo_q} <= res_d;
                    done_q       <= 1'b1;
                    cnt_q        <= '0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign OpReady = (state_q == S_IDLE);
    assign Busy    = ~OpReady;
    assign Done    = done_q;
    assign HI      = hi_q;
    assign LO      = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: 64-bit arithmetic reference model, per-cycle compare, directed literals and random traffic.
module tb_hilo_muldiv_unit;
    localparam int ITER = 32;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        OpValid = 1'b0;
    logic [2:0]  Op = 3'd0;
    logic [31:0] A = 32'd0, B = 32'd0;
    logic        OpReady, Busy, Done;
    logic [31:0] HI, LO;

    int n_checks = 0;
    int n_fail   = 0;

    hilo_muldiv_unit #(.DATA_W(32), .RADIX_BITS(1)) dut (
        .Clk(Clk), .Reset(Reset), .OpValid(OpValid), .Op(Op), .A(A), .B(B),
        .OpReady(OpReady), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: the whole product is known at accept, delivered ITER+1 edges later.
    logic [63:0] m_hilo = 64'd0;
    logic [63:0] m_res  = 64'd0;
    logic [63:0] m_p;
    int          m_rem  = 0;
    logic        m_done = 1'b0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_hilo = 64'd0; m_rem = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin m_hilo = m_res; m_done = 1'b1; end
            end else if (OpValid) begin
                case (Op)
                    3'd5: begin m_hilo[63:32] = A; m_done = 1'b1; end
                    3'd6: begin m_hilo[31:0]  = A; m_done = 1'b1; end
                    3'd1, 3'd2, 3'd3, 3'd4: begin
                        if (Op == 3'd2) m_p = {32'd0, A} * {32'd0, B};
                        else m_p = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
                        m_res = (Op == 3'd3) ? m_hilo + m_p :
                                (Op == 3'd4) ? m_hilo - m_p : m_p;
                        m_rem = ITER + 1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(posedge Clk) begin
        #2;
        chk("busy",    64'(Busy),    64'(m_rem != 0));
        chk("opready", 64'(OpReady), 64'(m_rem == 0));
        chk("done",    64'(Done),    64'(m_done));
        chk("hi",      64'(HI),      64'(m_hilo[63:32]));
        chk("lo",      64'(LO),      64'(m_hilo[31:0]));
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        OpValid = 1'b1; Op = op; A = a; B = b;
        @(negedge Clk);
        OpValid = 1'b0; Op = 3'd0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (Busy && n < 100) begin n++; @(negedge Clk); end
        if (n >= 100) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic chk_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
        chk({name, "_hi"}, 64'(HI), 64'(hi));
        chk({name, "_lo"}, 64'(LO), 64'(lo));
    endtask

    initial begin
        int n;
        logic [31:0] corners [6];
        corners[0] = 32'h0;        corners[1] = 32'h1;        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF; corners[5] = 32'hFFFF_FFFE;

        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        chk_hilo("reset", 32'h0, 32'h0);
        chk("reset_busy", 64'(Busy), 64'd0);
        chk("reset_done", 64'(Done), 64'd0);
        Reset = 1'b0;

        // Asynchronous reset between clock edges.
        issue(3'd5, 32'hDEAD_BEEF, 32'h0);
        issue(3'd6, 32'h1234_0000, 32'h0);
        chk_hilo("preload", 32'hDEAD_BEEF, 32'h1234_0000);
        #2 Reset = 1'b1;
        #1;
        chk_hilo("async_rst", 32'h0, 32'h0);
        chk("async_rst_busy",  64'(Busy),    64'd0);
        chk("async_rst_ready", 64'(OpReady), 64'd1);
        chk("async_rst_done",  64'(Done),    64'd0);
        @(negedge Clk) Reset = 1'b0;

        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(n);
        chk("multu_busy_cycles", 64'(n), 64'd33);
        chk("multu_done", 64'(Done), 64'd1);
        chk_hilo("multu_ff", 32'hFFFF_FFFE, 32'h0000_0001);

        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        chk_hilo("mult_m2x3", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000);
        wait_idle(n);
        chk_hilo("mult_min", 32'h4000_0000, 32'h0000_0000);

        // Back-to-back mthi/mtlo on consecutive edges.
        @(negedge Clk);
        OpValid = 1'b1; Op = 3'd5; A = 32'h1234_5678;
        @(negedge Clk);
        chk("mthi_done", 64'(Done), 64'd1);
        Op = 3'd6; A = 32'h0000_000A;
        @(negedge Clk);
        chk("mtlo_done", 64'(Done), 64'd1);
        OpValid = 1'b0; Op = 3'd0;
        issue(3'd3, 32'd2, 32'd5);
        wait_idle(n);
        chk_hilo("madd", 32'h1234_5678, 32'h0000_0014);
        issue(3'd4, 32'h20, 32'd1);
        wait_idle(n);
        chk_hilo("msub", 32'h1234_5677, 32'hFFFF_FFF4);

        // Requests and operand changes while busy are ignored.
        issue(3'd2, 32'd7, 32'd6);
        A = 32'hAAAA_5555; B = 32'h1357_9BDF;
        @(negedge Clk);
        OpValid = 1'b1; Op = 3'd5;
        @(negedge Clk);
        OpValid = 1'b0; Op = 3'd0; A = 32'h0; B = 32'hFFFF_FFFF;
        wait_idle(n);
        chk_hilo("multu_7x6", 32'h0, 32'h0000_002A);
        chk("multu_7x6_ready", 64'(OpReady), 64'd1);

        // Reset mid-multiply aborts it.
        issue(3'd2, 32'h0000_FFFF, 32'h0000_FFFF);
        repeat (9) @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        chk_hilo("abort", 32'h0, 32'h0);
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_done", 64'(Done), 64'd0);
        @(negedge Clk) Reset = 1'b0;
        issue(3'd1, 32'hFFFF_FFFD, 32'd7);
        wait_idle(n);
        chk_hilo("mult_after_abort", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // Random traffic, including requests while busy and ignored opcodes.
        for (int c = 0; c < 3000; c++) begin
            @(negedge Clk);
            OpValid = ($urandom_range(0, 2) == 0);
            Op = 3'($urandom_range(0, 7));
            A = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            B = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
        end
        @(negedge Clk);
        OpValid = 1'b0; Op = 3'd0;
        wait_idle(n);
        repeat (2) @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
